sifh_peak_scan: RTL and testbench

SIFH_PEAK_SCAN -- requirements
Module: sifh_peak_scan

---
 rtl/sifh_peak_scan_if.sv | 47 ++++
 rtl/sifh_peak_scan.sv | 200 ++++++++++++++++++++
 tb/tb_sifh_peak_scan.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sifh_peak_scan_if.sv
// ---------------------------------------------------------------------------
// sifh_peak_scan_if
// Purpose : Bundles the control handshake, histogram RAM port and peak result
//           signals of the peak scanner into one interface.
// Signals : start       - one-cycle scan request (to scanner)
//           busy, done  - scan status (from scanner)
//           ram_re, ram_raddr, ram_q        - histogram RAM read port
//           ram_we, ram_waddr, ram_wdata    - histogram RAM clear port
//           peak_valid, peak_pixel, peak_bin, peak_count - per-pixel result
// Modports: master - the scanner (drives RAM port and results)
//           slave  - the environment (drives start and RAM read data)
// ---------------------------------------------------------------------------
interface sifh_peak_scan_if #(
  parameter int PIXEL_NUM = 3,
  parameter int BIN_NUM   = 16,
  parameter int CNT_W     = 8,
  parameter int ADDR_W    = 6
);
  localparam int PIX_W = (PIXEL_NUM > 1) ? $clog2(PIXEL_NUM) : 1;
  localparam int BIN_W = (BIN_NUM > 1) ? $clog2(BIN_NUM) : 1;

  logic              start;
  logic              busy;
  logic              done;
  logic              ram_re;
  logic [ADDR_W-1:0] ram_raddr;
  logic [CNT_W-1:0]  ram_q;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [CNT_W-1:0]  ram_wdata;
  logic              peak_valid;
  logic [PIX_W-1:0]  peak_pixel;
  logic [BIN_W-1:0]  peak_bin;
  logic [CNT_W-1:0]  peak_count;

  modport master (
    input  start, ram_q,
    output busy, done, ram_re, ram_raddr, ram_we, ram_waddr, ram_wdata,
           peak_valid, peak_pixel, peak_bin, peak_count
  );

  modport slave (
    output start, ram_q,
    input  busy, done, ram_re, ram_raddr, ram_we, ram_waddr, ram_wdata,
           peak_valid, peak_pixel, peak_bin, peak_count
  );
endinterface

// File: rtl/sifh_peak_scan.sv
// ---------------------------------------------------------------------------
// sifh_peak_scan
// Purpose : On a start request, reads every bin of every pixel histogram from
//           a RAM with one-cycle read latency and reports, per pixel, the bin
//           holding the largest count (lowest bin wins on ties).
// Ports   : clk     - clock, all logic on the rising edge
//           res     - synchronous active-high reset
//           scan_io - sifh_peak_scan_if.master (start/busy/done, RAM read and
//                     clear ports, peak result strobe and values)
// Option  : define SIFH_PEAK_CLEAR_EN to zero every bin as its data is
//           consumed, readying the RAM for the next acquisition. Without it
//           the write port stays idle (ram_we = 0, ram_waddr = 0).
// ---------------------------------------------------------------------------
module sifh_peak_scan #(
  parameter int PIXEL_NUM = 3,
  parameter int BIN_NUM   = 16,
  parameter int CNT_W     = 8,
  parameter int ADDR_W    = 6
) (
  input logic               clk,
  input logic               res,
  sifh_peak_scan_if.master  scan_io
);
  localparam int PIX_W = (PIXEL_NUM > 1) ? $clog2(PIXEL_NUM) : 1;
  localparam int BIN_W = (BIN_NUM > 1) ? $clog2(BIN_NUM) : 1;
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIXEL_NUM - 1);
  localparam logic [BIN_W-1:0] BIN_LAST = BIN_W'(BIN_NUM - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_EMIT  = 3'd3,
    ST_FIN   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [PIX_W-1:0]   pixel_q, pixel_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  // Compare stage: qualifies ram_q and remembers which bin it belongs to.
  logic               cmp_vld_q;
  logic [BIN_W-1:0]   cmp_bin_q;
  logic [CNT_W-1:0]   max_q, max_d;
  logic [BIN_W-1:0]   max_bin_q, max_bin_d;

  logic               busy_q;
  logic               done_q;
  logic               ram_re_q;
  logic [ADDR_W-1:0]  ram_raddr_q;
  logic               ram_we_q;
  logic [ADDR_W-1:0]  ram_waddr_q;
  logic               peak_valid_q;
  logic [PIX_W-1:0]   peak_pixel_q;
  logic [BIN_W-1:0]   peak_bin_q;
  logic [CNT_W-1:0]   peak_count_q;

  // Linear RAM address of a (pixel, bin) pair.
  function automatic logic [ADDR_W-1:0] bin_addr(input logic [PIX_W-1:0] pix,
                                                 input logic [BIN_W-1:0] bin);
    return ADDR_W'(pix) * ADDR_W'(BIN_NUM) + ADDR_W'(bin);
  endfunction

  // Scan sequencing: next state, pixel and bin counters.
  always_comb begin
    state_d = state_q;
    pixel_d = pixel_q;
    bin_d   = bin_q;
    case (state_q)
      ST_IDLE: begin
        if (scan_io.start) begin
          state_d = ST_READ;
          pixel_d = '0;
          bin_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        if (bin_q == BIN_LAST) begin
          state_d = ST_DRAIN;
        end else begin
          bin_d = bin_q + BIN_W'(1);
        end
      end
      ST_DRAIN: state_d = ST_EMIT;
      ST_EMIT: begin
        if (pixel_q < PIX_LAST) begin
          state_d = ST_READ;
          pixel_d = pixel_q + PIX_W'(1);
          bin_d   = '0;
        end else begin
          state_d = ST_FIN;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Running maximum: strict greater-than keeps the lowest bin on ties. The
  // clear on entering READ never collides with a compare because EMIT or
  // IDLE always separates the last compare of a pixel from the next READ.
  always_comb begin
    max_d     = max_q;
    max_bin_d = max_bin_q;
    if (cmp_vld_q && (scan_io.ram_q > max_q)) begin
      max_d     = scan_io.ram_q;
      max_bin_d = cmp_bin_q;
    end else if ((state_d == ST_READ) && (state_q != ST_READ)) begin
      max_d     = '0;
      max_bin_d = '0;
    end else begin
      max_d     = max_q;
      max_bin_d = max_bin_q;
    end
  end

  // State, counters, compare stage and registered outputs. Status outputs
  // are decoded from the next state so they line up with the state itself.
  always_ff @(posedge clk) begin
    if (res) begin
      state_q      <= ST_IDLE;
      pixel_q      <= '0;
      bin_q        <= '0;
      cmp_vld_q    <= 1'b0;
      cmp_bin_q    <= '0;
      max_q        <= '0;
      max_bin_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ram_re_q     <= 1'b0;
      ram_raddr_q  <= '0;
      peak_valid_q <= 1'b0;
      peak_pixel_q <= '0;
      peak_bin_q   <= '0;
      peak_count_q <= '0;
    end else begin
      state_q      <= state_d;
      pixel_q      <= pixel_d;
      bin_q        <= bin_d;
      cmp_vld_q    <= ram_re_q;
      cmp_bin_q    <= bin_q;
      max_q        <= max_d;
      max_bin_q    <= max_bin_d;
      busy_q       <= (state_d == ST_READ) || (state_d == ST_DRAIN) ||
                      (state_d == ST_EMIT);
      done_q       <= (state_d == ST_FIN);
      ram_re_q     <= (state_d == ST_READ);
      ram_raddr_q  <= (state_d == ST_READ) ? bin_addr(pixel_d, bin_d) : '0;
      peak_valid_q <= (state_d == ST_EMIT);
      if (state_d == ST_EMIT) begin
        peak_pixel_q <= pixel_q;
        peak_bin_q   <= max_bin_d;
        peak_count_q <= max_d;
      end else begin
        peak_pixel_q <= peak_pixel_q;
        peak_bin_q   <= peak_bin_q;
        peak_count_q <= peak_count_q;
      end
    end
  end

`ifdef SIFH_PEAK_CLEAR_EN
  // Clear port: write zero to the word read last cycle, i.e. in the same
  // cycle its data is on ram_q and being consumed.
  always_ff @(posedge clk) begin
    if (res) begin
      ram_we_q    <= 1'b0;
      ram_waddr_q <= '0;
    end else begin
      ram_we_q    <= ram_re_q;
      ram_waddr_q <= ram_raddr_q;
    end
  end
`else
  // Clear port unused: held idle.
  always_ff @(posedge clk) begin
    if (res) begin
      ram_we_q    <= 1'b0;
      ram_waddr_q <= '0;
    end else begin
      ram_we_q    <= 1'b0;
      ram_waddr_q <= '0;
    end
  end
`endif

  assign scan_io.busy       = busy_q;
  assign scan_io.done       = done_q;
  assign scan_io.ram_re     = ram_re_q;
  assign scan_io.ram_raddr  = ram_raddr_q;
  assign scan_io.ram_we     = ram_we_q;
  assign scan_io.ram_waddr  = ram_waddr_q;
  assign scan_io.ram_wdata  = '0;
  assign scan_io.peak_valid = peak_valid_q;
  assign scan_io.peak_pixel = peak_pixel_q;
  assign scan_io.peak_bin   = peak_bin_q;
  assign scan_io.peak_count = peak_count_q;

endmodule

// File: tb/tb_sifh_peak_scan.sv
// ---------------------------------------------------------------------------
// tb_sifh_peak_scan
// Drives directed histogram images into a bench-side RAM, runs scans and
// checks every cycle against a timing/result model built from the scan rules
// (results spaced BIN_NUM+2 cycles apart, first-maximum per pixel), plus
// hand-computed expected peaks for each image.
// ---------------------------------------------------------------------------
module tb_sifh_peak_scan;
  localparam int PN      = 3;
  localparam int BN      = 16;
  localparam int CW      = 8;
  localparam int AW      = 6;
  localparam int WORDS   = PN * BN;
  localparam int PER     = BN + 2;     // cycles per pixel result
  localparam int FIN_REL = PER * PN;   // period index (from first READ) of done

  logic clk = 1'b0;
  logic res = 1'b1;

  sifh_peak_scan_if #(.PIXEL_NUM(PN), .BIN_NUM(BN), .CNT_W(CW), .ADDR_W(AW)) bus ();

  sifh_peak_scan #(.PIXEL_NUM(PN), .BIN_NUM(BN), .CNT_W(CW), .ADDR_W(AW)) dut (
    .clk     (clk),
    .res     (res),
    .scan_io (bus)
  );

  always #5 clk = ~clk;

  // Histogram RAM: one-cycle read latency, write port for clears.
  logic [CW-1:0] mem  [WORDS];
  logic [CW-1:0] gold [WORDS];
  logic          do_load = 1'b0;
  logic [CW-1:0] q_r = '0;
  assign bus.ram_q = q_r;

  always @(posedge clk) begin
    if (do_load) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= gold[i];
    end else if (bus.ram_we) begin
      mem[bus.ram_waddr] <= bus.ram_wdata;
    end
    if (bus.ram_re) q_r <= mem[bus.ram_raddr];
  end

  int   cyc = 0;
  logic start_smp = 1'b0;
  logic res_smp = 1'b1;
  always @(posedge clk) begin
    cyc       <= cyc + 1;
    start_smp <= bus.start;
    res_smp   <= res;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Model state
  bit   active = 1'b0;
  int   s = 0;
  int   exp_b [PN];
  int   exp_c [PN];
  int   pk_p = 0, pk_b = 0, pk_c = 0;
  int   log_n = 0;
  int   log_p [8];
  int   log_b [8];
  int   log_c [8];
  int   done_rel = -1;

  // Model + per-cycle compare
  initial begin
    forever begin
      @(negedge clk);
      if (res_smp) begin
        active = 1'b0;
        pk_p = 0; pk_b = 0; pk_c = 0;
      end else if (start_smp && !active) begin
        active = 1'b1;
        s = cyc;
        log_n = 0;
        done_rel = -1;
        for (int p = 0; p < PN; p++) begin
          exp_b[p] = 0;
          exp_c[p] = 0;
          for (int b = 0; b < BN; b++) begin
            if (int'(gold[p*BN+b]) > exp_c[p]) begin
              exp_c[p] = int'(gold[p*BN+b]);
              exp_b[p] = b;
            end
          end
        end
      end else if (active && (cyc - s > FIN_REL)) begin
        active = 1'b0;
`ifdef SIFH_PEAK_CLEAR_EN
        for (int i = 0; i < WORDS; i++) gold[i] = '0;
`endif
      end

      if (cyc > 0) begin
        int   rel;
        logic e_busy, e_done, e_pv, e_re, e_we;
        int   e_raddr, e_waddr;
        rel     = cyc - s;
        e_busy  = active && (rel < FIN_REL);
        e_done  = active && (rel == FIN_REL);
        e_pv    = active && (rel >= PER-1) && (rel < FIN_REL) && ((rel - (PER-1)) % PER == 0);
        e_re    = active && (rel < FIN_REL) && ((rel % PER) < BN);
        e_raddr = (rel / PER) * BN + (rel % PER);
`ifdef SIFH_PEAK_CLEAR_EN
        e_we    = active && (rel < FIN_REL) && ((rel % PER) >= 1) && ((rel % PER) <= BN);
        e_waddr = (rel / PER) * BN + (rel % PER) - 1;
`else
        e_we    = 1'b0;
        e_waddr = 0;
`endif
        if (e_pv) begin
          pk_p = (rel - (PER-1)) / PER;
          pk_b = exp_b[pk_p];
          pk_c = exp_c[pk_p];
        end
        check("busy", bus.busy, e_busy);
        check("done", bus.done, e_done);
        check("peak_valid", bus.peak_valid, e_pv);
        check("ram_re", bus.ram_re, e_re);
        if (e_re) check("ram_raddr", bus.ram_raddr, e_raddr);
        if (res_smp) check("ram_raddr_rst", bus.ram_raddr, 0);
        check("ram_we", bus.ram_we, e_we);
        if (e_we || res_smp) check("ram_waddr", bus.ram_waddr, e_we ? e_waddr : 0);
`ifndef SIFH_PEAK_CLEAR_EN
        check("ram_waddr_idle", bus.ram_waddr, 0);
`endif
        check("ram_wdata", bus.ram_wdata, 0);
        check("peak_pixel", bus.peak_pixel, pk_p);
        check("peak_bin", bus.peak_bin, pk_b);
        check("peak_count", bus.peak_count, pk_c);
        if (bus.peak_valid && log_n < 8) begin
          log_p[log_n] = int'(bus.peak_pixel);
          log_b[log_n] = int'(bus.peak_bin);
          log_c[log_n] = int'(bus.peak_count);
          log_n++;
        end
        if (bus.done && active) done_rel = rel;
      end
    end
  end

  task automatic load_mem();
    @(negedge clk);
    do_load = 1'b1;
    @(negedge clk);
    do_load = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!bus.done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", bus.done, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic run_scan(input bit extra_start);
    pulse_start();
    if (extra_start) begin
      repeat (5) @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
    end
    wait_done();
  endtask

  task automatic check_mem_vs_model();
    int bad;
    bad = 0;
    for (int i = 0; i < WORDS; i++) if (mem[i] !== gold[i]) bad++;
    check("mem_vs_model", bad, 0);
  endtask

  task automatic check_peaks(input string tag, input int b0, input int c0,
                             input int b1, input int c1, input int b2, input int c2);
    check({tag, "_count"}, log_n, 3);
    check({tag, "_pix0"}, log_p[0], 0);
    check({tag, "_bin0"}, log_b[0], b0);
    check({tag, "_cnt0"}, log_c[0], c0);
    check({tag, "_pix1"}, log_p[1], 1);
    check({tag, "_bin1"}, log_b[1], b1);
    check({tag, "_cnt1"}, log_c[1], c1);
    check({tag, "_pix2"}, log_p[2], 2);
    check({tag, "_bin2"}, log_b[2], b2);
    check({tag, "_cnt2"}, log_c[2], c2);
    check({tag, "_done_rel"}, done_rel, 54);
  endtask

  initial begin
    bus.start = 1'b0;
    // Image A: pixel0 peak 9 at bin 2, pixel1 tie of 7 at bins 5/11, pixel2 zero
    for (int i = 0; i < WORDS; i++) gold[i] = '0;
    gold[1] = 8'd3; gold[2] = 8'd9; gold[3] = 8'd2;
    for (int b = 0; b < BN; b++) gold[16+b] = CW'(b % 5);
    gold[21] = 8'd7; gold[27] = 8'd7;
    load_mem();
    repeat (2) @(negedge clk);
    res = 1'b0;
    repeat (2) @(negedge clk);

    run_scan(1'b0);
    check_peaks("scanA", 2, 9, 5, 7, 0, 0);
    check_mem_vs_model();
`ifdef SIFH_PEAK_CLEAR_EN
    begin
      int nz;
      nz = 0;
      for (int i = 0; i < WORDS; i++) if (mem[i] != 8'd0) nz++;
      check("cleared_words", nz, 0);
    end
`endif

    // Second scan, with a start during busy that must be ignored
    run_scan(1'b1);
`ifdef SIFH_PEAK_CLEAR_EN
    check_peaks("scanA2", 0, 0, 0, 0, 0, 0);
`else
    check_peaks("scanA2", 2, 9, 5, 7, 0, 0);
`endif
    check_mem_vs_model();

    // Image B: saturated counts, ties at 255, single peak in pixel2
    for (int i = 0; i < WORDS; i++) gold[i] = '0;
    gold[3] = 8'd254; gold[15] = 8'd255;
    for (int b = 0; b < BN; b++) gold[16+b] = 8'd1;
    gold[16] = 8'd255; gold[25] = 8'd255;
    gold[39] = 8'd128;
    load_mem();
    run_scan(1'b0);
    check_peaks("scanB", 15, 255, 0, 255, 7, 128);
    check_mem_vs_model();

    // Abort: reset during the scan at its tenth cycle, then restart
    load_mem();
    pulse_start();
    repeat (9) @(negedge clk);
    res = 1'b1;
    @(negedge clk);
    res = 1'b0;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done();
    check_peaks("scanB_after_abort", 15, 255, 0, 255, 7, 128);

    // Abort with no restart: nothing may be emitted
    pulse_start();
    repeat (9) @(negedge clk);
    res = 1'b1;
    @(negedge clk);
    res = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_no_peak", log_n, 0);
    check("abort_no_done", done_rel, -1);
    check("abort_idle_busy", bus.busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
